// File: rtl/read_return_arbiter.sv
// read_return_arbiter
// Picks one slave read burst at a time by round-robin and routes it to the
// master encoded in the upper ID bits. A slave is only eligible when the
// ordering FIFO for its {trans_id, master} names it as the next slave to
// return. One FIFO entry is popped per completed burst. The R datapath mux
// lives in the crossbar; this block only drives its selects and grants.
module read_return_arbiter #(
    parameter int M                     = 2,
    parameter int S                     = 2,
    parameter int NUM_OUTSTANDING_TRANS = 2,
    localparam int MW  = $clog2(M),
    localparam int SW  = $clog2(S),
    localparam int TW  = $clog2(NUM_OUTSTANDING_TRANS),
    localparam int IDW = MW + TW,
    localparam int NK  = M * NUM_OUTSTANDING_TRANS
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [S-1:0]        R_request_f,
    input  logic [S*IDW-1:0]    R_id_f,
    input  logic [S-1:0]        R_valid_f,
    input  logic [S-1:0]        R_last_f,
    input  logic [M-1:0]        R_ready_f,
    input  logic [NK*SW-1:0]    ord_sel_f,
    input  logic [NK-1:0]       ord_empty_f,
    output logic [NK-1:0]       ord_pop_f,
    output logic [S-1:0]        R_grant_f,
    output logic [SW-1:0]       R_slv_sel,
    output logic [MW-1:0]       R_mst_sel,
    output logic                R_active
);

    localparam int KW = (NK > 1) ? $clog2(NK) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] ptr;

    // Registered at grant time; routing and the pop use these, never the live ID.
    logic [SW-1:0] g_reg;
    logic [MW-1:0] mst_reg;
    logic [KW-1:0] k_reg;

    logic [SW-1:0] ord_head [NK];
    logic [MW-1:0] id_mst   [S];
    logic [TW-1:0] id_trn   [S];
    logic [KW-1:0] id_k     [S];
    logic [S-1:0]  id_ok;
    logic [S-1:0]  elig;

    logic          found;
    logic [SW-1:0] pick;
    logic [SW-1:0] cand;
    logic [SW-1:0] next_ptr;
    logic          beat_hs;
    logic          last_hs;

    // Unpack the ordering FIFO heads into one entry per k.
    for (genvar k = 0; k < NK; k++) begin : g_head
        assign ord_head[k] = ord_sel_f[k*SW +: SW];
    end

    // Per-slave ID decode and eligibility against the ordering FIFO head.
    // Out-of-range master or trans fields make the slave ineligible, which
    // also keeps the k lookup inside the FIFO array.
    for (genvar i = 0; i < S; i++) begin : g_elig
        assign id_mst[i] = R_id_f[i*IDW+TW +: MW];
        assign id_trn[i] = R_id_f[i*IDW +: TW];
        assign id_ok[i]  = (int'(id_mst[i]) < M) &&
                           (int'(id_trn[i]) < NUM_OUTSTANDING_TRANS);
        assign id_k[i]   = KW'(int'(id_trn[i]) * M + int'(id_mst[i]));
        assign elig[i]   = R_request_f[i] && id_ok[i] &&
                           !ord_empty_f[id_k[i]] &&
                           (ord_head[id_k[i]] == SW'(i));
    end

    // Round-robin search: first eligible slave at ptr, ptr+1, ... mod S.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int n = 0; n < S; n++) begin
            cand = SW'((int'(ptr) + n) % S);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign R_active = (state == ST_GRANT);
    assign beat_hs  = R_active && R_valid_f[g_reg] && R_ready_f[mst_reg];
    // A burst completing in a reset cycle is abandoned, so it never pops.
    assign last_hs  = beat_hs && R_last_f[g_reg] && !clr;
    assign next_ptr = (g_reg == SW'(S - 1)) ? '0 : g_reg + SW'(1);

    // Control FSM: grant on a successful search, release on the last handshake.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (last_hs) begin
                        state <= ST_IDLE;
                        ptr   <= next_ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the winner and its routing info; only meaningful while granted.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && found) begin
            g_reg   <= pick;
            mst_reg <= id_mst[pick];
            k_reg   <= id_k[pick];
        end
    end

    // One-hot grant towards the slaves.
    always_comb begin
        R_grant_f = '0;
        if (R_active) begin
            R_grant_f[g_reg] = 1'b1;
        end
    end

    assign R_slv_sel = R_active ? g_reg : '0;
    assign R_mst_sel = R_active ? mst_reg : '0;

    // Single-cycle pop of the ordering FIFO that owned the finished burst.
    always_comb begin
        ord_pop_f = '0;
        if (last_hs) begin
            ord_pop_f[k_reg] = 1'b1;
        end
    end

endmodule

// File: tb/tb_read_return_arbiter.sv
// Bench for read_return_arbiter (M=2, S=2, two IDs per master).
// Expected grants and pops go into queues as the stimulus is set up; a
// negedge monitor pops them when the DUT starts a grant or pulses a pop.
module tb_read_return_arbiter;

    logic       clk;
    logic       clr;
    logic [1:0] req;
    logic [3:0] id;
    logic [1:0] valid;
    logic [1:0] last;
    logic [1:0] ready;
    logic [3:0] ord_sel;
    logic [3:0] ord_empty;
    logic [3:0] ord_pop;
    logic [1:0] grant;
    logic [0:0] slv_sel;
    logic [0:0] mst_sel;
    logic       active;

    typedef struct {
        int slv;
        int mst;
    } gexp_t;

    gexp_t exp_g[$];
    int    exp_p[$];

    int    total = 0;
    int    bad   = 0;
    logic  act_q = 1'b0;

    read_return_arbiter #(
        .M(2),
        .S(2),
        .NUM_OUTSTANDING_TRANS(2)
    ) dut (
        .clk(clk),
        .clr(clr),
        .R_request_f(req),
        .R_id_f(id),
        .R_valid_f(valid),
        .R_last_f(last),
        .R_ready_f(ready),
        .ord_sel_f(ord_sel),
        .ord_empty_f(ord_empty),
        .ord_pop_f(ord_pop),
        .R_grant_f(grant),
        .R_slv_sel(slv_sel),
        .R_mst_sel(mst_sel),
        .R_active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req       = '0;
        id        = '0;
        valid     = '0;
        last      = '0;
        ready     = '0;
        ord_sel   = '0;
        ord_empty = 4'hF;
    endtask

    // Scoreboard side: a rising R_active consumes one expected grant, any
    // pop pulse consumes one expected FIFO index.
    always @(negedge clk) begin
        gexp_t e;
        int    k;
        if (active && !act_q) begin
            if (exp_g.size() == 0) begin
                chk("grant_unexp", 32'(grant), 0);
            end else begin
                e = exp_g.pop_front();
                chk("g_slv", 32'(slv_sel), 32'(e.slv));
                chk("g_mst", 32'(mst_sel), 32'(e.mst));
                chk("g_onehot", 32'(grant), 32'(1) << e.slv);
            end
        end
        if (ord_pop != 4'b0000) begin
            chk("pop_in_grant", 32'(active), 1);
            if (exp_p.size() == 0) begin
                chk("pop_unexp", 32'(ord_pop), 0);
            end else begin
                k = exp_p.pop_front();
                chk("pop_k", 32'(ord_pop), 32'(1) << k);
            end
        end
        act_q = active;
    end

    initial begin
        // Reset held two cycles with random inputs
        clr = 1'b1;
        idle_in();
        for (int c = 0; c < 2; c++) begin
            req       = 2'($urandom);
            id        = 4'($urandom);
            valid     = 2'($urandom);
            last      = 2'($urandom);
            ready     = 2'($urandom);
            ord_sel   = 4'($urandom);
            ord_empty = 4'($urandom);
            @(negedge clk);
            chk("rst_grant", 32'(grant), 0);
            chk("rst_active", 32'(active), 0);
            chk("rst_slv", 32'(slv_sel), 0);
            chk("rst_mst", 32'(mst_sel), 0);
            chk("rst_pop", 32'(ord_pop), 0);
            step();
        end
        clr = 1'b0;
        idle_in();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("idle_active", 32'(active), 0);
            chk("idle_grant", 32'(grant), 0);
            chk("idle_pop", 32'(ord_pop), 0);
            step();
        end

        // Single 4-beat burst: slave 1, ID 2'b10 -> master 1, trans 0, k=1
        idle_in();
        req[1] = 1'b1; id[3:2] = 2'b10;
        ord_empty[1] = 1'b0; ord_sel[1] = 1'b1;
        valid[1] = 1'b1; ready[1] = 1'b1;
        exp_g.push_back('{1, 1});
        @(negedge clk);
        chk("sb_lat", 32'(active), 0);
        for (int b = 1; b <= 4; b++) begin
            step();
            last[1] = (b == 4);
            if (b == 4) exp_p.push_back(1);
            @(negedge clk);
            chk("sb_act", 32'(active), 1);
            chk("sb_slv", 32'(slv_sel), 1);
            chk("sb_mst", 32'(mst_sel), 1);
            chk("sb_pop", 32'(ord_pop), (b == 4) ? 32'h2 : 32'h0);
        end
        step();
        idle_in();
        @(negedge clk);
        chk("sb_rel", 32'(active), 0);
        chk("sb_rel_grant", 32'(grant), 0);

        // Ordering block: slave 0 ID 0 (k=0) while head of k=0 is slave 1
        step();
        idle_in();
        req[0] = 1'b1; id[1:0] = 2'b00;
        ord_empty[0] = 1'b0; ord_sel[0] = 1'b1;
        valid[0] = 1'b1; last[0] = 1'b1; ready[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("ob_block", 32'(active), 0);
            step();
        end
        ord_sel[0] = 1'b0;
        exp_g.push_back('{0, 0});
        @(negedge clk);
        chk("ob_vis", 32'(active), 0);
        step();
        exp_p.push_back(0);
        @(negedge clk);
        chk("ob_grant", 32'(active), 1);
        chk("ob_pop", 32'(ord_pop), 32'h1);
        step();
        idle_in();
        @(negedge clk);
        chk("ob_1cyc", 32'(active), 0);

        // Round-robin, both eligible, 1-beat bursts. ptr is 1 after the
        // slave 0 burst, so slave 1 goes first: 1,0,1,0 with bubbles.
        step();
        idle_in();
        req = 2'b11; id = {2'b01, 2'b00};
        ord_empty[0] = 1'b0; ord_sel[0] = 1'b0;
        ord_empty[2] = 1'b0; ord_sel[2] = 1'b1;
        valid = 2'b11; last = 2'b11; ready[0] = 1'b1;
        exp_g.push_back('{1, 0}); exp_g.push_back('{0, 0});
        exp_g.push_back('{1, 0}); exp_g.push_back('{0, 0});
        exp_p.push_back(2); exp_p.push_back(0);
        exp_p.push_back(2); exp_p.push_back(0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("rr_act", 32'(active), 32'(j % 2));
            if (j % 2 == 1) chk("rr_slv", 32'(slv_sel), (j == 1 || j == 5) ? 32'h1 : 32'h0);
            step();
        end
        idle_in();
        @(negedge clk);
        chk("rr_end", 32'(active), 0);

        // Backpressure on master 0 for 5 cycles with R_last already high
        step();
        idle_in();
        req[0] = 1'b1; id[1:0] = 2'b00;
        ord_empty[0] = 1'b0; ord_sel[0] = 1'b0;
        valid[0] = 1'b1; ready = 2'b11;
        exp_g.push_back('{0, 0});
        @(negedge clk);
        chk("bp_lat", 32'(active), 0);
        for (int j = 0; j < 2; j++) begin
            step();
            @(negedge clk);
            chk("bp_beat", 32'(active), 1);
            chk("bp_beat_pop", 32'(ord_pop), 0);
        end
        step();
        ready[0] = 1'b0; last[0] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("bp_hold", 32'(active), 1);
            chk("bp_nopop", 32'(ord_pop), 0);
            step();
        end
        ready[0] = 1'b1;
        exp_p.push_back(0);
        @(negedge clk);
        chk("bp_last", 32'(active), 1);
        chk("bp_pop", 32'(ord_pop), 32'h1);
        step();
        idle_in();
        @(negedge clk);
        chk("bp_rel", 32'(active), 0);

        // Mid-burst reset on a slave 1 burst, then ptr must be back at 0
        step();
        idle_in();
        req[1] = 1'b1; id[3:2] = 2'b10;
        ord_empty[1] = 1'b0; ord_sel[1] = 1'b1;
        valid[1] = 1'b1; ready[1] = 1'b1;
        exp_g.push_back('{1, 1});
        @(negedge clk);
        chk("mr_lat", 32'(active), 0);
        step();
        @(negedge clk);
        chk("mr_grant", 32'(active), 1);
        step();
        clr = 1'b1; last[1] = 1'b1;
        @(negedge clk);
        chk("mr_clr_pop", 32'(ord_pop), 0);
        step();
        clr = 1'b0; last[1] = 1'b0;
        req[0] = 1'b1; id[1:0] = 2'b00;
        ord_empty[0] = 1'b0; ord_sel[0] = 1'b0;
        valid[0] = 1'b1; last[0] = 1'b1; ready[0] = 1'b1;
        exp_g.push_back('{0, 0});
        @(negedge clk);
        chk("mr_drop", 32'(active), 0);
        chk("mr_drop_grant", 32'(grant), 0);
        chk("mr_drop_pop", 32'(ord_pop), 0);
        step();
        exp_p.push_back(0);
        @(negedge clk);
        chk("mr_ptr0", 32'(active), 1);
        chk("mr_ptr0_slv", 32'(slv_sel), 0);
        step();
        req[0] = 1'b0; ord_empty[0] = 1'b1; valid[0] = 1'b0; last[1] = 1'b1;
        exp_g.push_back('{1, 1});
        @(negedge clk);
        chk("mr_bubble", 32'(active), 0);
        step();
        exp_p.push_back(1);
        @(negedge clk);
        chk("mr_regrant", 32'(active), 1);
        chk("mr_regrant_slv", 32'(slv_sel), 1);
        chk("mr_regrant_pop", 32'(ord_pop), 32'h2);
        step();
        idle_in();
        @(negedge clk);
        chk("mr_end", 32'(active), 0);

        repeat (3) step();
        chk("gq_left", 32'(exp_g.size()), 0);
        chk("pq_left", 32'(exp_p.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
